ap_line_sequencer: RTL



---
 rtl/ap_seq_pkg.sv | 38 +++
 rtl/ap_line_sequencer_if.sv | 23 ++
 rtl/ap_seq_watchdog.sv | 32 +++
 rtl/ap_line_sequencer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/ap_seq_pkg.sv
// Shared definitions for the AP/Data line sequencer: op codes, one-hot
// FSM state constants, the latched step descriptor and op decode helpers.
package ap_seq_pkg;

    localparam int unsigned OP_WIDTH    = 3;
    localparam int unsigned STATE_WIDTH = 4;

    // Decoded Brainfuck data ops; codes 5-7 are illegal.
    localparam logic [OP_WIDTH-1:0] OP_INC   = 3'd0;
    localparam logic [OP_WIDTH-1:0] OP_DEC   = 3'd1;
    localparam logic [OP_WIDTH-1:0] OP_LEFT  = 3'd2;
    localparam logic [OP_WIDTH-1:0] OP_RIGHT = 3'd3;
    localparam logic [OP_WIDTH-1:0] OP_TEST  = 3'd4;

    // One-hot sequencer states.
    localparam logic [STATE_WIDTH-1:0] ST_IDLE  = 4'b0001;
    localparam logic [STATE_WIDTH-1:0] ST_ISSUE = 4'b0010;
    localparam logic [STATE_WIDTH-1:0] ST_WAIT  = 4'b0100;
    localparam logic [STATE_WIDTH-1:0] ST_DONE  = 4'b1000;

    // Per-op step descriptor latched at accept: which request line, which direction.
    typedef struct packed {
        logic ap;   // 1 = step the address pointer, 0 = step the data cell
        logic dec;  // 1 = decrement
    } step_t;

    function automatic logic op_is_legal(input logic [OP_WIDTH-1:0] op);
        return op <= OP_TEST;
    endfunction

    function automatic step_t op_step(input logic [OP_WIDTH-1:0] op);
        step_t s;
        s.ap  = (op == OP_LEFT) || (op == OP_RIGHT);
        s.dec = (op == OP_DEC)  || (op == OP_LEFT);
        return s;
    endfunction

endpackage

// File: rtl/ap_line_sequencer_if.sv
// AP/Data line handshake bundle.
//   master (sequencer): drives ApRequest, DataRequest, Dec; samples LineReady, DataZero, ApZero
//   slave  (line)     : the reverse
interface ap_line_sequencer_if;

    logic ApRequest;
    logic DataRequest;
    logic Dec;
    logic LineReady;
    logic DataZero;
    logic ApZero;

    modport master (
        output ApRequest, DataRequest, Dec,
        input  LineReady, DataZero, ApZero
    );

    modport slave (
        input  ApRequest, DataRequest, Dec,
        output LineReady, DataZero, ApZero
    );

endinterface

// File: rtl/ap_seq_watchdog.sv
// Per-request watchdog for the line sequencer (built only with AP_SEQ_TIMEOUT_EN).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   run        : sequencer is in WAIT; counts cycles
//   clear      : sequencer is in ISSUE; restarts the count
//   expired_c  : combinational, high in the LIMIT-th consecutive WAIT cycle
module ap_seq_watchdog #(
    parameter int unsigned LIMIT = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic expired_c
);

    localparam int unsigned CNT_WIDTH = (LIMIT > 2) ? $clog2(LIMIT) : 1;

    logic [CNT_WIDTH-1:0] cnt_q;

    assign expired_c = run && (cnt_q == CNT_WIDTH'(LIMIT - 1));

    // Count WAIT cycles; hold at the limit so expiry is a single event per request.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (run && !expired_c) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/ap_line_sequencer.sv
// Initiator side of the AP/Data line handshake. Accepts a decoded data op
// with a repeat count and expands it into single-step line requests, waiting
// on line Ready between steps; TEST ops capture DataZero for the loop unit.
// Optional build macro: AP_SEQ_TIMEOUT_EN adds a per-request watchdog and
// the Timeout port.
// Ports:
//   Clk, Rst          : clock, synchronous active-high reset
//   OpValid/Op/Count  : op offered by the decoder (held until accepted)
//   OpReady           : combinational, sequencer idle and line idle
//   OpDone            : one-cycle pulse when the accepted op completes
//   TestZero          : DataZero captured by the last TEST op
//   Fault             : sticky, illegal op or LEFT issued at address zero
//   Busy              : state is not IDLE
//   line (master)     : ApRequest, DataRequest, Dec out; LineReady, DataZero, ApZero in
//   Timeout           : sticky watchdog flag (AP_SEQ_TIMEOUT_EN only)
module ap_line_sequencer
    import ap_seq_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH    = 8,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   OpValid,
    input  logic [OP_WIDTH-1:0]    Op,
    input  logic [COUNT_WIDTH-1:0] Count,
    output logic                   OpReady,
    output logic                   OpDone,
    output logic                   TestZero,
    output logic                   Fault,
    output logic                   Busy,
    ap_line_sequencer_if.master    line
`ifdef AP_SEQ_TIMEOUT_EN
    ,
    output logic                   Timeout
`endif
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end
    if (COUNT_WIDTH < 1) begin : g_bad_count
        $error("COUNT_WIDTH must be at least 1");
    end

    logic [STATE_WIDTH-1:0] state_q, state_d;
    step_t                  step_q, step_d;
    logic [COUNT_WIDTH-1:0] rem_q, rem_d;
    logic                   first_wait_q, first_wait_d;
    logic                   test_zero_q, test_zero_d;
    logic                   fault_q, fault_d;
    logic                   op_done_q, op_done_d;
    logic                   busy_q, busy_d;
    logic                   ap_req_q, ap_req_d;
    logic                   data_req_q, data_req_d;
    logic                   accept_c;
    logic                   wd_expired_c;

    assign OpReady  = (state_q == ST_IDLE) && line.LineReady && !Rst;
    assign accept_c = OpValid && OpReady;

`ifdef AP_SEQ_TIMEOUT_EN
    logic timeout_q;

    ap_seq_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (Clk),
        .rst       (Rst),
        .run       (state_q == ST_WAIT),
        .clear     (state_q == ST_ISSUE),
        .expired_c (wd_expired_c)
    );

    // Sticky until reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            timeout_q <= 1'b0;
        end else if (wd_expired_c) begin
            timeout_q <= 1'b1;
        end
    end

    assign Timeout = timeout_q;
`else
    assign wd_expired_c = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= ST_IDLE;
            step_q       <= '0;
            rem_q        <= '0;
            first_wait_q <= 1'b0;
            test_zero_q  <= 1'b0;
            fault_q      <= 1'b0;
            op_done_q    <= 1'b0;
            busy_q       <= 1'b0;
            ap_req_q     <= 1'b0;
            data_req_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            rem_q        <= rem_d;
            first_wait_q <= first_wait_d;
            test_zero_q  <= test_zero_d;
            fault_q      <= fault_d;
            op_done_q    <= op_done_d;
            busy_q       <= busy_d;
            ap_req_q     <= ap_req_d;
            data_req_q   <= data_req_d;
        end
    end

    // Next state and next registered outputs.
    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        rem_d        = rem_q;
        first_wait_d = 1'b0;
        test_zero_d  = test_zero_q;
        fault_d      = fault_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    step_d = op_step(Op);
                    rem_d  = Count;
                    if (Count == '0) begin
                        state_d = ST_DONE;
                    end else if (Op == OP_TEST) begin
                        test_zero_d = line.DataZero;
                        state_d     = ST_DONE;
                    end else if (!op_is_legal(Op)) begin
                        fault_d = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        // LEFT at address zero still executes; the line wraps.
                        if (Op == OP_LEFT && line.ApZero) begin
                            fault_d = 1'b1;
                        end
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                state_d      = ST_WAIT;
                first_wait_d = 1'b1;
            end
            ST_WAIT: begin
                // First WAIT cycle ignores Ready: the line may not have dropped it yet.
                if (wd_expired_c) begin
                    state_d = ST_DONE;
                end else if (!first_wait_q && line.LineReady) begin
                    rem_d   = rem_q - COUNT_WIDTH'(1);
                    state_d = (rem_q == COUNT_WIDTH'(1)) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        op_done_d  = (state_d == ST_DONE);
        busy_d     = (state_d != ST_IDLE);
        ap_req_d   = (state_d == ST_ISSUE) &&  step_d.ap;
        data_req_d = (state_d == ST_ISSUE) && !step_d.ap;
    end

    assign OpDone           = op_done_q;
    assign TestZero         = test_zero_q;
    assign Fault            = fault_q;
    assign Busy             = busy_q;
    assign line.ApRequest   = ap_req_q;
    assign line.DataRequest = data_req_q;
    assign line.Dec         = step_q.dec;

endmodule
